// File: rtl/ft_lockstep_checker.sv
// Lockstep checker for two redundant cores.
// Compares fetch and data-bus requests each cycle. On a qualified divergence it
// pulses error_o, blocks the memory write, and runs a halt / register-restore /
// resume sequence that copies core 0's register file into core 1.
module ft_lockstep_checker #(
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int NREGS       = 32,
  parameter int HALT_CYCLES = 2,
  parameter int CNT_W       = 8
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic                      enable_i,
  input  logic                      instr_req_0_i,
  input  logic                      instr_req_1_i,
  input  logic [ADDR_W-1:0]         instr_addr_0_i,
  input  logic [ADDR_W-1:0]         instr_addr_1_i,
  input  logic                      data_req_0_i,
  input  logic                      data_req_1_i,
  input  logic                      data_we_0_i,
  input  logic                      data_we_1_i,
  input  logic [ADDR_W-1:0]         data_addr_0_i,
  input  logic [ADDR_W-1:0]         data_addr_1_i,
  input  logic [DATA_W-1:0]         data_wdata_0_i,
  input  logic [DATA_W-1:0]         data_wdata_1_i,
  output logic                      data_we_block_o,
  output logic                      error_o,
  output logic [1:0]                mismatch_o,
  output logic                      halt_o,
  output logic                      restore_valid_o,
  input  logic                      restore_ready_i,
  output logic [$clog2(NREGS)-1:0]  restore_idx_o,
  output logic                      resume_o,
  output logic [CNT_W-1:0]          error_count_o
);

  localparam int IDX_W = $clog2(NREGS);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NREGS - 1);

  typedef enum logic [1:0] {
    S_CHECK,
    S_HALT,
    S_COPY,
    S_RESUME
  } state_e;

  state_e           state_q;
  logic [3:0]       halt_cnt_q;
  logic [IDX_W-1:0] idx_q;
  logic             error_q;
  logic [1:0]       mismatch_q;
  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;

  logic mi;
  logic md;
  logic mq;

  // Divergence detection: request presence must match, and payload only
  // matters when both cores actually issue the request.
  assign mi = (instr_req_0_i != instr_req_1_i) |
              (instr_req_0_i & instr_req_1_i & (instr_addr_0_i != instr_addr_1_i));

  assign md = (data_req_0_i != data_req_1_i) |
              (data_req_0_i & data_req_1_i &
               ((data_we_0_i != data_we_1_i) |
                (data_addr_0_i != data_addr_1_i) |
                (data_we_0_i & data_we_1_i & (data_wdata_0_i != data_wdata_1_i))));

  assign mq = enable_i & (state_q == S_CHECK) & (mi | md);

  // Saturating increment of the detection counter.
  assign count_d = (count_q == {CNT_W{1'b1}}) ? count_q : count_q + 1'b1;

  // Recovery FSM with its registered status outputs.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= S_CHECK;
      halt_cnt_q <= 4'd0;
      idx_q      <= '0;
      error_q    <= 1'b0;
      mismatch_q <= 2'b00;
      count_q    <= '0;
    end else begin
      error_q <= 1'b0;
      case (state_q)
        S_CHECK: begin
          if (mq) begin
            state_q    <= S_HALT;
            error_q    <= 1'b1;
            mismatch_q <= {md, mi};
            count_q    <= count_d;
            halt_cnt_q <= 4'(HALT_CYCLES - 1);
          end
        end
        S_HALT: begin
          if (halt_cnt_q == 4'd0) begin
            state_q <= S_COPY;
            idx_q   <= IDX_W'(1);
          end else begin
            halt_cnt_q <= halt_cnt_q - 4'd1;
          end
        end
        S_COPY: begin
          // Index only advances on a completed handshake; no timeout.
          if (restore_ready_i) begin
            if (idx_q == LAST_IDX) begin
              state_q <= S_RESUME;
              idx_q   <= '0;
            end else begin
              idx_q <= idx_q + 1'b1;
            end
          end
        end
        S_RESUME: begin
          state_q <= S_CHECK;
        end
        default: begin
          state_q <= S_CHECK;
        end
      endcase
    end
  end

  // Write blocking is combinational so the corrupt write never lands; all
  // writes stay blocked while recovery is in progress.
  assign data_we_block_o = (md & enable_i) | (state_q != S_CHECK);

  assign error_o         = error_q;
  assign mismatch_o      = mismatch_q;
  assign halt_o          = (state_q == S_HALT) | (state_q == S_COPY);
  assign restore_valid_o = (state_q == S_COPY);
  assign restore_idx_o   = idx_q;
  assign resume_o        = (state_q == S_RESUME);
  assign error_count_o   = count_q;

endmodule

// File: tb/tb_ft_lockstep_checker.sv
// Directed testbench for ft_lockstep_checker (counter width 2 to reach saturation).
module tb_ft_lockstep_checker;

  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;
  localparam int NREGS  = 32;
  localparam int HALT_C = 2;
  localparam int CNT_W  = 2;

  logic              clk;
  logic              rst;
  logic              enable;
  logic              ireq0, ireq1;
  logic [ADDR_W-1:0] iaddr0, iaddr1;
  logic              dreq0, dreq1, dwe0, dwe1;
  logic [ADDR_W-1:0] daddr0, daddr1;
  logic [DATA_W-1:0] wdata0, wdata1;
  logic              we_block, error, halt, rvalid, rready, resume;
  logic [1:0]        mismatch;
  logic [4:0]        ridx;
  logic [CNT_W-1:0]  ecount;

  int total_checks;
  int passed_checks;

  ft_lockstep_checker #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .NREGS(NREGS),
    .HALT_CYCLES(HALT_C), .CNT_W(CNT_W)
  ) dut (
    .clk_i(clk), .rst_i(rst), .enable_i(enable),
    .instr_req_0_i(ireq0), .instr_req_1_i(ireq1),
    .instr_addr_0_i(iaddr0), .instr_addr_1_i(iaddr1),
    .data_req_0_i(dreq0), .data_req_1_i(dreq1),
    .data_we_0_i(dwe0), .data_we_1_i(dwe1),
    .data_addr_0_i(daddr0), .data_addr_1_i(daddr1),
    .data_wdata_0_i(wdata0), .data_wdata_1_i(wdata1),
    .data_we_block_o(we_block), .error_o(error), .mismatch_o(mismatch),
    .halt_o(halt), .restore_valid_o(rvalid), .restore_ready_i(rready),
    .restore_idx_o(ridx), .resume_o(resume), .error_count_o(ecount)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total_checks++;
    if (got !== exp)
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    else
      passed_checks++;
  endtask

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    ireq0 = 0; ireq1 = 0; iaddr0 = '0; iaddr1 = '0;
    dreq0 = 0; dreq1 = 0; dwe0 = 0; dwe1 = 0;
    daddr0 = '0; daddr1 = '0; wdata0 = '0; wdata1 = '0;
  endtask

  task automatic instr_fault();
    ireq0 = 1; ireq1 = 1; iaddr0 = 32'h10; iaddr1 = 32'h14;
  endtask

  // Wait (bounded) for the resume pulse, then step into CHECK.
  task automatic wait_resume(input string tag);
    int n;
    n = 0;
    while (!resume && n < 200) begin
      tick();
      n++;
    end
    chk(tag, {31'd0, resume}, 32'd1);
    tick();
  endtask

  // Wait (bounded) until COPY presents the given index.
  task automatic wait_idx(input string tag, input int idx);
    int n;
    n = 0;
    while (!(rvalid && ridx == 5'(idx)) && n < 200) begin
      tick();
      n++;
    end
    chk(tag, {31'd0, rvalid}, 32'd1);
    chk({tag, "_idx"}, {27'd0, ridx}, 32'(idx));
  endtask

  initial begin
    int cyc;
    int first_valid;
    int exp_idx;
    logic err_seen;
    logic blk_seen;

    total_checks = 0;
    passed_checks = 0;
    idle();
    enable = 1;
    rready = 1;
    rst = 1;
    tick();
    tick();
    rst = 0;

    // Reset state
    chk("rst_error", {31'd0, error}, 0);
    chk("rst_mismatch", {30'd0, mismatch}, 0);
    chk("rst_halt", {31'd0, halt}, 0);
    chk("rst_valid", {31'd0, rvalid}, 0);
    chk("rst_idx", {27'd0, ridx}, 0);
    chk("rst_resume", {31'd0, resume}, 0);
    chk("rst_count", {30'd0, ecount}, 0);
    chk("rst_block", {31'd0, we_block}, 0);
    $display("reset released");

    // Identical streams
    err_seen = 0;
    blk_seen = 0;
    for (int i = 0; i <= 16; i++) begin
      ireq0 = 1; ireq1 = 1; iaddr0 = 32'(i * 4); iaddr1 = 32'(i * 4);
      dreq0 = 1; dreq1 = 1; dwe0 = 1; dwe1 = 1;
      daddr0 = 32'h100 + 32'(i * 4); daddr1 = daddr0;
      wdata0 = 32'(i); wdata1 = 32'(i);
      #1;
      blk_seen |= we_block;
      tick();
      err_seen |= error;
    end
    idle();
    chk("ident_error", {31'd0, err_seen}, 0);
    chk("ident_block", {31'd0, blk_seen}, 0);
    chk("ident_count", {30'd0, ecount}, 0);
    $display("identical streams: 17 fetches");

    // Instruction mismatch
    instr_fault();
    tick();
    idle();
    chk("imis_error", {31'd0, error}, 1);
    chk("imis_mismatch", {30'd0, mismatch}, 32'b01);
    chk("imis_count", {30'd0, ecount}, 1);
    chk("imis_halt", {31'd0, halt}, 1);
    tick();
    chk("imis_error_drop", {31'd0, error}, 0);
    chk("imis_halt_held", {31'd0, halt}, 1);
    wait_resume("imis_resume");
    chk("imis_halt_off", {31'd0, halt}, 0);
    chk("imis_mismatch_held", {30'd0, mismatch}, 32'b01);
    $display("instruction mismatch recovered");

    // Backpressure at idx 7 plus an ignored fault during COPY
    instr_fault();
    tick();
    idle();
    chk("bp_count", {30'd0, ecount}, 2);
    wait_idx("bp_at7", 7);
    rready = 0;
    instr_fault();
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("bp_idx_hold", {27'd0, ridx}, 7);
      chk("bp_valid_hold", {31'd0, rvalid}, 1);
      chk("bp_no_error", {31'd0, error}, 0);
    end
    idle();
    rready = 1;
    chk("bp_count_kept", {30'd0, ecount}, 2);
    wait_resume("bp_resume");
    $display("backpressure held idx 7 for 5 cycles");

    // Data write mismatch with full restore timing
    dreq0 = 1; dreq1 = 1; dwe0 = 1; dwe1 = 1;
    daddr0 = 32'h100; daddr1 = 32'h100; wdata0 = 32'hA5; wdata1 = 32'hA4;
    #1;
    chk("dmis_block", {31'd0, we_block}, 1);
    tick();
    idle();
    chk("dmis_error", {31'd0, error}, 1);
    chk("dmis_mismatch", {30'd0, mismatch}, 32'b10);
    chk("dmis_count", {30'd0, ecount}, 3);
    cyc = 1;
    first_valid = 0;
    exp_idx = 1;
    while (!resume && cyc < 200) begin
      if (rvalid) begin
        if (first_valid == 0) first_valid = cyc;
        chk("dmis_idx_step", {27'd0, ridx}, 32'(exp_idx));
        exp_idx++;
      end
      tick();
      cyc++;
    end
    chk("dmis_first_valid", 32'(first_valid), 32'(1 + HALT_C));
    chk("dmis_handshakes", 32'(exp_idx - 1), 32'(NREGS - 1));
    chk("dmis_resume_cycle", 32'(cyc), 32'(HALT_C + (NREGS - 1) + 1));
    chk("dmis_resume", {31'd0, resume}, 1);
    tick();
    $display("data mismatch: resume after %0d cycles", cyc);

    // Reset mid-COPY at idx 12
    instr_fault();
    tick();
    idle();
    wait_idx("rc_at12", 12);
    rst = 1;
    tick();
    rst = 0;
    chk("rc_error", {31'd0, error}, 0);
    chk("rc_mismatch", {30'd0, mismatch}, 0);
    chk("rc_halt", {31'd0, halt}, 0);
    chk("rc_valid", {31'd0, rvalid}, 0);
    chk("rc_idx", {27'd0, ridx}, 0);
    chk("rc_resume", {31'd0, resume}, 0);
    chk("rc_count", {30'd0, ecount}, 0);
    chk("rc_block", {31'd0, we_block}, 0);
    $display("reset mid-COPY cleared state");

    // Saturation over 5 recoveries
    for (int i = 0; i < 5; i++) begin
      instr_fault();
      tick();
      idle();
      chk("sat_count", {30'd0, ecount}, (i + 1 > 3) ? 3 : 32'(i + 1));
      wait_resume("sat_resume");
    end
    $display("saturation: count %0d after 5 recoveries", ecount);

    // Enable low: no flag, no block
    enable = 0;
    instr_fault();
    dreq0 = 1; dreq1 = 1; dwe0 = 1; dwe1 = 1;
    daddr0 = 32'h200; daddr1 = 32'h204; wdata0 = 1; wdata1 = 2;
    #1;
    chk("en0_block", {31'd0, we_block}, 0);
    tick();
    chk("en0_error", {31'd0, error}, 0);
    chk("en0_halt", {31'd0, halt}, 0);
    $display("enable low: divergence ignored");

    // Simultaneous instruction and data mismatch: single pulse, 2'b11
    enable = 1;
    #1;
    chk("both_block", {31'd0, we_block}, 1);
    tick();
    idle();
    chk("both_error", {31'd0, error}, 1);
    chk("both_mismatch", {30'd0, mismatch}, 32'b11);
    tick();
    chk("both_error_drop", {31'd0, error}, 0);
    wait_resume("both_resume");
    $display("simultaneous mismatch: one pulse");

    $display("%0d/%0d checks passed", passed_checks, total_checks);
    $finish;
  end

endmodule
